// File: rtl/alu_result_collector.sv
// Tracks ops through the ALU pipeline, captures each result when it is due,
// and queues tagged results in an in-order show-ahead FIFO with issue credit.
module alu_result_collector #(
  parameter int data_width  = 32,
  parameter int op_width    = 3,
  parameter int alu_latency = 2,
  parameter int depth       = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      issue_i,
  input  logic [op_width-1:0]       issue_op_i,
  input  logic [op_width-1:0]       issue_sel_i,
  input  logic                      issue_arith_i,
  input  logic                      issue_shift_i,
  input  logic [data_width-1:0]     data_out_i,
  output logic                      issue_ok_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [data_width-1:0]     res_data_o,
  output logic [op_width-1:0]       res_op_o,
  output logic [op_width-1:0]       res_sel_o,
  output logic                      res_arith_o,
  output logic                      res_shift_o,
  output logic [$clog2(depth):0]    res_count_o,
  output logic                      overflow_err_o
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam int EW = data_width + 2 * op_width + 2;

  logic [alu_latency-1:0] pipe_valid_q;
  logic [op_width-1:0]    pipe_op_q    [alu_latency];
  logic [op_width-1:0]    pipe_sel_q   [alu_latency];
  logic [alu_latency-1:0] pipe_arith_q;
  logic [alu_latency-1:0] pipe_shift_q;

  logic [EW-1:0] mem_q [depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, full, do_write;
  logic [31:0]   inflight;
  logic [EW-1:0] wr_entry;

  // Tag pipeline mirrors the ALU latency; the last stage marks a result due now.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_valid_q <= '0;
      pipe_arith_q <= '0;
      pipe_shift_q <= '0;
      for (int i = 0; i < alu_latency; i++) begin
        pipe_op_q[i]  <= '0;
        pipe_sel_q[i] <= '0;
      end
    end else begin
      pipe_valid_q[0] <= issue_i;
      pipe_op_q[0]    <= issue_op_i;
      pipe_sel_q[0]   <= issue_sel_i;
      pipe_arith_q[0] <= issue_arith_i;
      pipe_shift_q[0] <= issue_shift_i;
      for (int i = 1; i < alu_latency; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_op_q[i]    <= pipe_op_q[i-1];
        pipe_sel_q[i]   <= pipe_sel_q[i-1];
        pipe_arith_q[i] <= pipe_arith_q[i-1];
        pipe_shift_q[i] <= pipe_shift_q[i-1];
      end
    end
  end

  assign push     = pipe_valid_q[alu_latency-1];
  assign pop      = res_valid_o && res_ready_i;
  assign full     = (count_q == CW'(depth));
  // A simultaneous pop frees the slot being written, so a full push is still legal.
  assign do_write = push && (!full || pop);
  assign wr_entry = {data_out_i, pipe_op_q[alu_latency-1], pipe_sel_q[alu_latency-1],
                     pipe_arith_q[alu_latency-1], pipe_shift_q[alu_latency-1]};

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(do_write);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + CW'(do_write) - CW'(pop);
    overflow_d = overflow_q | (push && full && !pop);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (do_write) begin
        mem_q[wr_ptr_q] <= wr_entry;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < alu_latency; i++) begin
      inflight = inflight + 32'(pipe_valid_q[i]);
    end
  end

  assign issue_ok_o     = (32'(count_q) + inflight) < 32'(depth);
  assign res_valid_o    = (count_q != '0);
  assign res_count_o    = count_q;
  assign overflow_err_o = overflow_q;
  assign {res_data_o, res_op_o, res_sel_o, res_arith_o, res_shift_o} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: capture timing, credit, overflow,
// full push+pop, async reset mid-flight and pointer wrap.
module tb_alu_result_collector;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        issue_i;
  logic [2:0]  issue_op_i;
  logic [2:0]  issue_sel_i;
  logic        issue_arith_i;
  logic        issue_shift_i;
  logic [31:0] data_out_i;
  logic        issue_ok_o;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_data_o;
  logic [2:0]  res_op_o;
  logic [2:0]  res_sel_o;
  logic        res_arith_o;
  logic        res_shift_o;
  logic [2:0]  res_count_o;
  logic        overflow_err_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_collector #(
    .data_width(32), .op_width(3), .alu_latency(2), .depth(4)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .issue_i(issue_i),
    .issue_op_i(issue_op_i), .issue_sel_i(issue_sel_i),
    .issue_arith_i(issue_arith_i), .issue_shift_i(issue_shift_i),
    .data_out_i(data_out_i), .issue_ok_o(issue_ok_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_op_o(res_op_o), .res_sel_o(res_sel_o),
    .res_arith_o(res_arith_o), .res_shift_o(res_shift_o),
    .res_count_o(res_count_o), .overflow_err_o(overflow_err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; issue_i = 0; issue_op_i = 0; issue_sel_i = 0;
    issue_arith_i = 0; issue_shift_i = 0; data_out_i = 0; res_ready_i = 1;
    #2;
    n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", res_valid_o); end
    n_cmp++; if (res_count_o !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", res_count_o); end
    n_cmp++; if (issue_ok_o !== 1'b1) begin n_err++; $display("FAIL reset_issue_ok got=%b exp=1", issue_ok_o); end
    n_cmp++; if (overflow_err_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow_err_o); end
    n_cmp++; if (res_data_o !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", res_data_o); end
    tick(); tick();
    reset_i = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    res_ready_i = 1;
    issue_i = 1; issue_op_i = 3'b010; issue_sel_i = 3'b001; issue_arith_i = 1; issue_shift_i = 0;
    tick();
    issue_i = 0; issue_op_i = 0; issue_sel_i = 0; issue_arith_i = 0;
    tick();
    n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL single_early got=%b exp=0", res_valid_o); end
    data_out_i = 32'hDEAD_BEEF;
    tick();
    data_out_i = 0;
    n_cmp++; if (res_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", res_valid_o); end
    n_cmp++; if (res_data_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data got=%h exp=deadbeef", res_data_o); end
    n_cmp++; if ({res_op_o, res_sel_o, res_arith_o, res_shift_o} !== {3'b010, 3'b001, 1'b1, 1'b0})
      begin n_err++; $display("FAIL single_tags got=%b%b%b%b exp=010 001 1 0", res_op_o, res_sel_o, res_arith_o, res_shift_o); end
    tick();
    n_cmp++; if (res_valid_o !== 1'b0 || res_count_o !== 3'd0)
      begin n_err++; $display("FAIL single_drain got valid=%b count=%0d exp valid=0 count=0", res_valid_o, res_count_o); end
    $display("test_single done");
  endtask

  task automatic test_fill_overflow();
    res_ready_i = 0;
    for (int c = 0; c < 6; c++) begin
      issue_i = (c < 4);
      issue_op_i = 3'(c);
      data_out_i = (c >= 2) ? 32'(c - 1) : 32'h0;
      tick();
      if (c == 1) begin
        n_cmp++; if (issue_ok_o !== 1'b1) begin n_err++; $display("FAIL fill_credit_early got=%b exp=1", issue_ok_o); end
      end
      if (c == 3) begin
        n_cmp++; if (issue_ok_o !== 1'b0) begin n_err++; $display("FAIL fill_credit_full got=%b exp=0", issue_ok_o); end
      end
    end
    issue_i = 0; data_out_i = 0;
    n_cmp++; if (res_count_o !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", res_count_o); end
    // Fifth op issued regardless of credit; its result must be dropped.
    issue_i = 1; issue_op_i = 3'd7;
    tick();
    issue_i = 0;
    tick();
    data_out_i = 32'hFFFF_0000;
    tick();
    data_out_i = 0;
    n_cmp++; if (overflow_err_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow_err_o); end
    n_cmp++; if (res_count_o !== 3'd4) begin n_err++; $display("FAIL ovf_count got=%0d exp=4", res_count_o); end
    tick(); tick();
    n_cmp++; if (overflow_err_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err_o); end
    res_ready_i = 1;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (res_valid_o !== 1'b1 || res_data_o !== 32'(k))
        begin n_err++; $display("FAIL ovf_drain%0d got valid=%b data=%h exp data=%h", k, res_valid_o, res_data_o, 32'(k)); end
      tick();
    end
    n_cmp++; if (res_count_o !== 3'd0 || issue_ok_o !== 1'b1)
      begin n_err++; $display("FAIL ovf_empty got count=%0d ok=%b exp 0/1", res_count_o, issue_ok_o); end
    $display("test_fill_overflow done");
  endtask

  task automatic test_reset_mid();
    res_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      issue_i = 1;
      data_out_i = (c == 2) ? 32'h77 : 32'h0;
      tick();
    end
    issue_i = 0;
    n_cmp++; if (res_count_o !== 3'd1) begin n_err++; $display("FAIL rmid_pre_count got=%0d exp=1", res_count_o); end
    #2 reset_i = 1'b1;
    #1;
    n_cmp++; if (res_valid_o !== 1'b0 || res_count_o !== 3'd0)
      begin n_err++; $display("FAIL rmid_async got valid=%b count=%0d exp 0/0", res_valid_o, res_count_o); end
    n_cmp++; if (overflow_err_o !== 1'b0 || issue_ok_o !== 1'b1)
      begin n_err++; $display("FAIL rmid_flags got ovf=%b ok=%b exp 0/1", overflow_err_o, issue_ok_o); end
    #1 reset_i = 1'b0;
    res_ready_i = 1;
    for (int c = 0; c < 5; c++) begin
      data_out_i = 32'h1000 + 32'(c);
      tick();
      n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_ghost%0d got valid=%b exp=0", c, res_valid_o); end
    end
    data_out_i = 0;
    $display("test_reset_mid done");
  endtask

  task automatic test_full_push_pop();
    for (int c = 0; c < 7; c++) begin
      issue_i = (c < 5);
      data_out_i = (c >= 2) ? 32'(c - 1) : 32'h0;
      res_ready_i = (c == 6);
      tick();
      if (c == 5) begin
        n_cmp++; if (res_count_o !== 3'd4 || res_data_o !== 32'd1)
          begin n_err++; $display("FAIL fpp_full got count=%0d head=%h exp 4/1", res_count_o, res_data_o); end
      end
    end
    n_cmp++; if (res_count_o !== 3'd4 || res_data_o !== 32'd2)
      begin n_err++; $display("FAIL fpp_both got count=%0d head=%h exp 4/2", res_count_o, res_data_o); end
    n_cmp++; if (overflow_err_o !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got=%b exp=0", overflow_err_o); end
    issue_i = 0; data_out_i = 0; res_ready_i = 1;
    for (int k = 2; k <= 5; k++) begin
      n_cmp++; if (res_valid_o !== 1'b1 || res_data_o !== 32'(k))
        begin n_err++; $display("FAIL fpp_drain%0d got valid=%b data=%h exp data=%h", k, res_valid_o, res_data_o, 32'(k)); end
      tick();
    end
    n_cmp++; if (res_count_o !== 3'd0) begin n_err++; $display("FAIL fpp_empty got=%0d exp=0", res_count_o); end
    $display("test_full_push_pop done");
  endtask

  task automatic test_wrap();
    int iss[100];
    int issued;
    int exp_idx;
    issued = 0; exp_idx = 0;
    for (int i = 0; i < 100; i++) iss[i] = -1;
    for (int c = 0; c < 100 && exp_idx < 10; c++) begin
      res_ready_i = (c % 2 == 0);
      if (res_valid_o && res_ready_i) begin
        n_cmp++; if (res_data_o !== 32'(exp_idx))
          begin n_err++; $display("FAIL wrap_order got=%h exp=%h", res_data_o, 32'(exp_idx)); end
        $display("wrap pop %0d data=%h", exp_idx, res_data_o);
        exp_idx++;
      end
      if (issued < 10 && issue_ok_o) begin
        issue_i = 1; iss[c] = issued; issued++;
      end else begin
        issue_i = 0;
      end
      data_out_i = (c >= 2 && iss[c-2] >= 0) ? 32'(iss[c-2]) : 32'hBAD0_0000;
      tick();
    end
    issue_i = 0; data_out_i = 0;
    n_cmp++; if (exp_idx != 10) begin n_err++; $display("FAIL wrap_count got=%0d exp=10", exp_idx); end
    n_cmp++; if (overflow_err_o !== 1'b0 || res_count_o !== 3'd0)
      begin n_err++; $display("FAIL wrap_end got ovf=%b count=%0d exp 0/0", overflow_err_o, res_count_o); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_reset_mid();
    test_full_push_pop();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
